// File: rtl/restoring_divider_4bit_pkg.sv
// rtl/restoring_divider_4bit_pkg.sv - shared constants and state encoding for the restoring divider
package restoring_divider_4bit_pkg;

    localparam int DIV_W = 4;

    // Quotient reported when the divisor is zero (all ones, like a saturated result)
    localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 4'hF;

    // Index of the last iteration; the counter runs down from here to zero
    localparam logic [1:0] LAST_ITER = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/borrow_lookahead_subtractor_5bit.sv
// rtl/borrow_lookahead_subtractor_5bit.sv - 5-bit a-b with lookahead borrow chain, borrow-in tied to 0
module borrow_lookahead_subtractor_5bit (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] diff,
    output logic       bout
);

    logic [4:0] g;
    logic [4:0] p;
    logic [5:0] borrow;
    logic       term;
    logic       acc;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Each borrow is the OR of every lower generate propagated through the bits above it
    always_comb begin
        borrow = '0;
        term   = 1'b0;
        acc    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            borrow[i+1] = acc;
        end
    end

    assign diff = a ^ b ^ borrow[4:0];
    assign bout = borrow[5];

endmodule

// File: rtl/restoring_divider_4bit.sv
// rtl/restoring_divider_4bit.sv - multi-cycle 4-bit unsigned restoring divider, one quotient bit per clock
module restoring_divider_4bit
    import restoring_divider_4bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    div_state_t       state_next;
    logic [DIV_W-1:0] q_work;
    logic [DIV_W-1:0] r_work;
    logic [DIV_W-1:0] d_reg;
    logic [1:0]       count;

    logic [4:0]       trial;
    logic             trial_borrow;
    logic             restore;
    logic [DIV_W-1:0] q_iter;
    logic [DIV_W-1:0] r_iter;

    borrow_lookahead_subtractor_5bit u_trial_sub (
        .a    ({r_work, q_work[DIV_W-1]}),
        .b    ({1'b0, d_reg}),
        .diff (trial),
        .bout (trial_borrow)
    );

    // A negative trial shows up both as borrow-out and as trial[4]; either one means restore
    assign restore = trial_borrow | trial[4];
    assign r_iter  = restore ? {r_work[DIV_W-2:0], q_work[DIV_W-1]} : trial[DIV_W-1:0];
    assign q_iter  = {q_work[DIV_W-2:0], ~restore};

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (count == 2'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (enable) begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            done  <= (state_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_work      <= '0;
            r_work      <= '0;
            d_reg       <= '0;
            count       <= 2'd0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (enable) begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= DBZ_QUOTIENT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            q_work      <= dividend;
                            d_reg       <= divisor;
                            r_work      <= '0;
                            count       <= LAST_ITER;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    q_work <= q_iter;
                    r_work <= r_iter;
                    if (count == 2'd0) begin
                        quotient  <= q_iter;
                        remainder <= r_iter;
                    end else begin
                        count <= count - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// tb/tb_restoring_divider_4bit.sv - scoreboard bench for restoring_divider_4bit
module tb_restoring_divider_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [3:0] dd;
        logic [3:0] dv;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic done_prev = 1'b0;

    restoring_divider_4bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] dd, input logic [3:0] dv);
        exp_t e;
        int   a = int'(dd);
        int   b = int'(dv);
        e.dd = dd;
        e.dv = dv;
        if (b == 0) begin
            e.q = 4'hF;
            e.r = dd;
            e.z = 1'b1;
        end else begin
            e.q = 4'(a / b);
            e.r = 4'(a % b);
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Monitor: each rising done retires one expected result
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 8'd1, 8'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("quotient %0d/%0d", e.dd, e.dv), 8'(quotient), 8'(e.q));
                check($sformatf("remainder %0d/%0d", e.dd, e.dv), 8'(remainder), 8'(e.r));
                check($sformatf("div_by_zero %0d/%0d", e.dd, e.dv), 8'(div_by_zero), 8'(e.z));
            end
        end
        done_prev = done;
    end

    // stall_mode: 0 none, 1 random, 2 two stalls in mid-CALC. Entered and left at a negedge with busy=0.
    task automatic run_op(input logic [3:0] dd, input logic [3:0] dv, input int stall_mode, input bit poke);
        int   cycles = 0;
        int   stalls_pre = 0;
        int   stalls_all = 0;
        int   busy_cycles = 0;
        bit   seen_done = 0;
        bit   finished = 0;
        bit   last_en = 1;
        logic [10:0] snap = '0;
        int   base_lat = (dv == 0) ? 0 : 4;
        int   base_busy = (dv == 0) ? 1 : 5;

        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        enable   = 1'b1;
        sb.push_back(model(dd, dv));
        @(negedge clk);
        start = 1'b0;
        for (int guard = 0; guard < 60; guard++) begin
            if (busy) busy_cycles++;
            if (!last_en)
                check("hold_during_stall", 8'({busy, done, quotient}), 8'(snap[10:5]));
            if (!last_en)
                check("hold_remainder", 8'({remainder, div_by_zero}), 8'(snap[4:0]));
            if (done && !seen_done) begin
                seen_done = 1;
                check($sformatf("done_latency %0d/%0d", dd, dv), 8'(cycles), 8'(base_lat + stalls_pre));
            end
            if (!busy) begin
                finished = 1;
                break;
            end
            snap = {busy, done, quotient, remainder, div_by_zero};
            case (stall_mode)
                1:       enable = ($urandom_range(0, 3) != 0);
                2:       enable = !(cycles == 1 || cycles == 2);
                default: enable = 1'b1;
            endcase
            if (!enable) begin
                stalls_all++;
                if (!seen_done) stalls_pre++;
            end
            if (poke && cycles == 0) begin
                start    = 1'b1;
                dividend = 4'd7;
                divisor  = 4'd2;
            end else begin
                start = 1'b0;
            end
            last_en = enable;
            @(negedge clk);
            cycles++;
        end
        start  = 1'b0;
        enable = 1'b1;
        if (!finished) check("timeout_waiting_idle", 8'd0, 8'd1);
        check($sformatf("done_seen %0d/%0d", dd, dv), 8'(seen_done), 8'd1);
        check($sformatf("busy_cycles %0d/%0d", dd, dv), 8'(busy_cycles), 8'(base_busy + stalls_all));
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 8'(busy), 8'd0);
        check("reset_done", 8'(done), 8'd0);
        check("reset_quotient", 8'(quotient), 8'd0);
        check("reset_remainder", 8'(remainder), 8'd0);
        check("reset_dbz", 8'(div_by_zero), 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd13, 4'd4, 0, 0);
        run_op(4'd15, 4'd1, 0, 0);
        run_op(4'd5,  4'd7, 0, 0);
        run_op(4'd0,  4'd3, 0, 0);
        run_op(4'd9,  4'd0, 0, 0);
        run_op(4'd8,  4'd2, 0, 0);
        run_op(4'd14, 4'd3, 2, 0);
        run_op(4'd12, 4'd5, 0, 1);

        // Reset in the middle of a calculation; previous results (2,2) must clear
        dividend = 4'd11;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", 8'(busy), 8'd0);
        check("midreset_done", 8'(done), 8'd0);
        check("midreset_quotient", 8'(quotient), 8'd0);
        check("midreset_remainder", 8'(remainder), 8'd0);
        check("midreset_dbz", 8'(div_by_zero), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_after_reset", 8'(busy), 8'd0);

        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                run_op(4'(dd), 4'(dv), 1, ($urandom_range(0, 7) == 0));
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
